// File: rtl/iot_sensor_pkg.sv
// Shared IoT sensor-channel types and constants.
// Power modes, sensor addresses and the poller state encoding.
package iot_sensor_pkg;

  localparam logic [1:0] PWR_NORMAL = 2'd0;
  localparam logic [1:0] PWR_LOW    = 2'd1;
  localparam logic [1:0] PWR_SLEEP  = 2'd2;

  localparam logic [6:0] ADDR_TEMP     = 7'h48;
  localparam logic [6:0] ADDR_HUMIDITY = 7'h40;
  localparam logic [6:0] ADDR_PRESSURE = 7'h77;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_READ,
    ST_DONE,
    ST_ERROR
  } poller_state_e;

endpackage

// File: rtl/i2c_sensor_poller_if.sv
// Request/response port between a sensor poller and the shared I2C master.
// master: the poller side; slave: the I2C master side.
interface i2c_sensor_poller_if;

  logic       start_read;
  logic [6:0] slave_addr;
  logic       read_write_n;
  logic [7:0] write_data;
  logic [7:0] i2c_read_data;
  logic       transaction_done;
  logic       ack_error;

  modport master (
    output start_read, slave_addr, read_write_n, write_data,
    input  i2c_read_data, transaction_done, ack_error
  );

  modport slave (
    input  start_read, slave_addr, read_write_n, write_data,
    output i2c_read_data, transaction_done, ack_error
  );

endinterface

// File: rtl/i2c_sensor_poller_timer.sv
// Loadable down-counter used to pace sensor polls.
// Stops at zero; load has priority over decrement.
module poll_interval_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/i2c_sensor_poller.sv
// Periodic N-byte big-endian I2C sensor poller.
// Retries failed frames and bounds the wait for each byte.
module i2c_sensor_poller
  import iot_sensor_pkg::*;
#(
  parameter int         NUM_BYTES       = 2,
  parameter logic [6:0] SLAVE_ADDR      = ADDR_TEMP,
  parameter int         INTERVAL_NORMAL = 50000,
  parameter int         INTERVAL_LOW    = 100000,
  parameter int         INTERVAL_SLEEP  = 200000,
  parameter int         CNT_W           = 20,
  parameter int         MAX_RETRIES     = 2,
  parameter int         TIMEOUT_CYCLES  = 4096,
  localparam int        DATA_W          = 8 * NUM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        power_mode,
  output logic [DATA_W-1:0] sensor_data,
  output logic              data_valid,
  output logic              sensor_error,
  output logic              busy,
  output logic [1:0]        retry_count,
  i2c_sensor_poller_if.master bus
);

  localparam int TO_W =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  poller_state_e state, next;

  logic [1:0]        idx;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W+7:0] cat;
  logic [DATA_W-1:0] frame;
  logic [CNT_W-1:0]  sel_val;
  logic [CNT_W-1:0]  load_val;
  logic              t_load;
  logic              t_zero;
  logic              byte_ok;
  logic              byte_bad;
  logic              last;
  logic              can_retry;

  assign bus.slave_addr   = SLAVE_ADDR;
  assign bus.read_write_n = 1'b1;
  assign bus.write_data   = 8'h00;

  assign cat   = {shift, bus.i2c_read_data};
  assign frame = cat[DATA_W-1:0];
  assign last  = (idx == 2'(NUM_BYTES - 1));

  assign can_retry = (int'(retry_count) < MAX_RETRIES);

  // ack_error wins over a simultaneous done; done wins over timeout
  assign byte_ok  = (state == ST_READ) && bus.transaction_done
                    && !bus.ack_error;
  assign byte_bad = (state == ST_READ)
                    && (bus.ack_error
                        || (!bus.transaction_done
                            && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)));

  always_comb begin
    sel_val = CNT_W'(INTERVAL_NORMAL);
    unique case (1'b1)
      (power_mode == PWR_LOW):   sel_val = CNT_W'(INTERVAL_LOW);
      (power_mode == PWR_SLEEP): sel_val = CNT_W'(INTERVAL_SLEEP);
      default:                   sel_val = CNT_W'(INTERVAL_NORMAL);
    endcase
  end

  // idle holds the normal load until enable picks the live mode
  assign load_val = (state == ST_IDLE && !enable)
                    ? CNT_W'(INTERVAL_NORMAL) : sel_val;
  assign t_load   = (state == ST_IDLE) || (state == ST_DONE)
                    || (state == ST_ERROR);

  poll_interval_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (load_val),
    .dec      (state == ST_WAIT),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    if (!enable) begin
      next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  next = ST_WAIT;
        ST_WAIT:  if (t_zero) next = ST_START;
        ST_START: next = ST_READ;
        ST_READ: begin
          if (byte_bad) begin
            next = can_retry ? ST_START : ST_ERROR;
          end else if (byte_ok) begin
            next = last ? ST_DONE : ST_START;
          end
        end
        ST_DONE:  next = ST_WAIT;
        ST_ERROR: next = ST_WAIT;
        default:  next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.start_read = (state == ST_START);
    data_valid     = (state == ST_DONE);
    sensor_error   = (state == ST_ERROR);
    busy           = (state == ST_START) || (state == ST_READ)
                     || (state == ST_DONE) || (state == ST_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      to_cnt      <= '0;
      shift       <= '0;
      sensor_data <= '0;
      retry_count <= '0;
    end else begin
      if (state == ST_START) begin
        to_cnt <= '0;
      end else if (state == ST_READ) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (state == ST_WAIT && next == ST_START) begin
        idx         <= '0;
        retry_count <= '0;
      end
      if (state == ST_READ && next == ST_START) begin
        if (byte_bad) begin
          idx         <= '0;
          retry_count <= retry_count + 2'd1;
        end else begin
          idx   <= idx + 2'd1;
          shift <= frame;
        end
      end
      // published on the edge that enters DONE so it is stable with data_valid
      if (state == ST_READ && next == ST_DONE) begin
        sensor_data <= frame;
      end
    end
  end

endmodule
